irq_ctrl: RTL and testbench



---
 rtl/cotm32_pkg.sv | 30 +++
 rtl/irq_ctrl_if.sv | 26 ++
 rtl/sync_ff.sv | 23 ++
 rtl/irq_ctrl.sv | 123 ++++++++++++
 tb/tb_irq_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cotm32_pkg.sv
// Shared core constants: machine interrupt bit positions, cause codes and the
// interrupt controller state type.
package cotm32_pkg;

  localparam int XLEN = 32;

  localparam int MIP_MSIP = 3;
  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    INTRAP
  } irq_state_e;

  // Interrupt mcause: interrupt flag in the MSB, code zero-extended below it.
  function automatic logic [XLEN-1:0] irq_cause(input logic [3:0] code);
    logic [XLEN-1:0] c;
    c            = '0;
    c[XLEN-1]    = 1'b1;
    c[3:0]       = code;
    return c;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Interrupt controller bus: pending sources and CSR inputs in, mip view and
// trap request out. slave = controller side, master = core/peripheral side.
interface irq_ctrl_if;

  logic                        i_mtip;
  logic                        i_msip;
  logic                        i_meip_async;
  logic                        i_mstatus_mie;
  logic [cotm32_pkg::XLEN-1:0] i_mie;
  logic                        i_take;
  logic                        i_mret;
  logic [cotm32_pkg::XLEN-1:0] o_mip;
  logic                        o_irq_req;
  logic [cotm32_pkg::XLEN-1:0] o_irq_cause;

  modport slave (
    input  i_mtip, i_msip, i_meip_async, i_mstatus_mie, i_mie, i_take, i_mret,
    output o_mip, o_irq_req, o_irq_cause
  );

  modport master (
    output i_mtip, i_msip, i_meip_async, i_mstatus_mie, i_mie, i_take, i_mret,
    input  o_mip, o_irq_req, o_irq_cause
  );

endinterface

// File: rtl/sync_ff.sv
// Generic N-stage single-bit synchronizer; output follows d after STAGES clocks.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: mip view, mie/MIE masking, fixed priority,
// held trap request. IRQ_CTRL_EXT_EDGE_EN makes MEIP a sticky edge-set bit.
module irq_ctrl
  import cotm32_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  irq_ctrl_if.slave  bus
);

  irq_state_e      state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mip;
  logic            mtip_q, msip_q, meip, meip_sync;
  logic            pend_mei, pend_msi, pend_mti;
  logic            unused_mie_bits;

  sync_ff #(.STAGES(SYNC_STAGES)) u_meip_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (bus.i_meip_async),
    .q   (meip_sync)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mtip_q <= 1'b0;
      msip_q <= 1'b0;
    end else begin
      mtip_q <= bus.i_mtip;
      msip_q <= bus.i_msip;
    end
  end

`ifdef IRQ_CTRL_EXT_EDGE_EN
  logic meip_prev, meip_pend, take_mei;

  assign take_mei = bus.i_take && (state_q == REQ) && (cause_q[3:0] == IRQ_CODE_MEI);

  // A fresh rising edge beats the clear from accepting the previous one.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meip_prev <= 1'b0;
      meip_pend <= 1'b0;
    end else begin
      meip_prev <= meip_sync;
      if (meip_sync && !meip_prev) begin
        meip_pend <= 1'b1;
      end else if (take_mei) begin
        meip_pend <= 1'b0;
      end
    end
  end

  assign meip = meip_pend;
`else
  assign meip = meip_sync;
`endif

  always_comb begin
    mip           = '0;
    mip[MIP_MSIP] = msip_q;
    mip[MIP_MTIP] = mtip_q;
    mip[MIP_MEIP] = meip;
  end

  assign pend_mei = mip[MIP_MEIP] & bus.i_mie[MIP_MEIP];
  assign pend_msi = mip[MIP_MSIP] & bus.i_mie[MIP_MSIP];
  assign pend_mti = mip[MIP_MTIP] & bus.i_mie[MIP_MTIP];

  assign unused_mie_bits = ^{bus.i_mie[XLEN-1:12], bus.i_mie[10:8],
                             bus.i_mie[6:4], bus.i_mie[2:0]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Cause is captured only on IDLE->REQ, so it stays frozen while requesting.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (bus.i_mstatus_mie && (pend_mei || pend_msi || pend_mti)) begin
          state_d = REQ;
          if (pend_mei) begin
            cause_d = irq_cause(IRQ_CODE_MEI);
          end else if (pend_msi) begin
            cause_d = irq_cause(IRQ_CODE_MSI);
          end else begin
            cause_d = irq_cause(IRQ_CODE_MTI);
          end
        end
      end
      REQ: begin
        if (bus.i_take) begin
          state_d = INTRAP;
        end else if (!bus.i_mstatus_mie) begin
          state_d = IDLE;
        end
      end
      INTRAP: begin
        if (bus.i_mret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_mip       = mip;
  assign bus.o_irq_req   = (state_q == REQ);
  assign bus.o_irq_cause = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl built with a 3-stage external synchronizer.
module tb_irq_ctrl;

  localparam int          SYNC = 3;
`ifdef IRQ_CTRL_EXT_EDGE_EN
  localparam int          MEI_LAT = SYNC + 1;
`else
  localparam int          MEI_LAT = SYNC;
`endif
  localparam logic [31:0] C_MSI = 32'h8000_0003;
  localparam logic [31:0] C_MTI = 32'h8000_0007;
  localparam logic [31:0] C_MEI = 32'h8000_000B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.i_mtip         = 1'b0;
    bus.i_msip         = 1'b0;
    bus.i_meip_async   = 1'b0;
    bus.i_mstatus_mie  = 1'b0;
    bus.i_mie          = '0;
    bus.i_take         = 1'b0;
    bus.i_mret         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_mip !== 32'h0) begin errors++; $display("FAIL reset_mip got=%h want=%h", bus.o_mip, 32'h0); end
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.o_irq_req); end
    checks++; if (bus.o_irq_cause !== 32'h0) begin errors++; $display("FAIL reset_cause got=%h want=%h", bus.o_irq_cause, 32'h0); end
  endtask

  task automatic test_timer();
    do_reset();
    bus.i_mie = 32'h80; bus.i_mstatus_mie = 1'b1; bus.i_mtip = 1'b1;
    tick(1);
    checks++; if (bus.o_mip !== 32'h80) begin errors++; $display("FAIL timer_mip got=%h want=%h", bus.o_mip, 32'h80); end
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL timer_req_early got=%b want=0", bus.o_irq_req); end
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL timer_req got=%b want=1", bus.o_irq_req); end
    checks++; if (bus.o_irq_cause !== C_MTI) begin errors++; $display("FAIL timer_cause got=%h want=%h", bus.o_irq_cause, C_MTI); end
    bus.i_take = 1'b1; tick(1); bus.i_take = 1'b0;
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL timer_take got=%b want=0", bus.o_irq_req); end
    tick(3);
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL timer_intrap got=%b want=0", bus.o_irq_req); end
    bus.i_mret = 1'b1; tick(1); bus.i_mret = 1'b0;
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL timer_mret_cycle got=%b want=0", bus.o_irq_req); end
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL timer_rereq got=%b want=1", bus.o_irq_req); end
  endtask

  task automatic test_priority();
    do_reset();
    bus.i_mie = 32'h888;
    bus.i_mtip = 1'b1; bus.i_msip = 1'b1; bus.i_meip_async = 1'b1;
    tick(6);
    checks++; if (bus.o_mip !== 32'h888) begin errors++; $display("FAIL prio_mip got=%h want=%h", bus.o_mip, 32'h888); end
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL prio_masked got=%b want=0", bus.o_irq_req); end
    bus.i_mstatus_mie = 1'b1;
    tick(1);
    checks++; if (bus.o_irq_cause !== C_MEI) begin errors++; $display("FAIL prio_all_cause got=%h want=%h", bus.o_irq_cause, C_MEI); end
    bus.i_take = 1'b1; tick(1); bus.i_take = 1'b0;
    bus.i_mie = 32'h088;
    bus.i_mret = 1'b1; tick(1); bus.i_mret = 1'b0;
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL prio_nomei_req got=%b want=1", bus.o_irq_req); end
    checks++; if (bus.o_irq_cause !== C_MSI) begin errors++; $display("FAIL prio_nomei_cause got=%h want=%h", bus.o_irq_cause, C_MSI); end
  endtask

  task automatic test_freeze();
    do_reset();
    bus.i_mie = 32'h888; bus.i_mstatus_mie = 1'b1; bus.i_mtip = 1'b1;
    tick(2);
    bus.i_meip_async = 1'b1; bus.i_msip = 1'b1;
    tick(6);
    checks++; if (bus.o_irq_cause !== C_MTI) begin errors++; $display("FAIL freeze_higher got=%h want=%h", bus.o_irq_cause, C_MTI); end
    bus.i_mtip = 1'b0;
    tick(2);
    checks++; if (bus.o_irq_req !== 1'b1 || bus.o_irq_cause !== C_MTI) begin errors++; $display("FAIL freeze_drop got=%b/%h want=1/%h", bus.o_irq_req, bus.o_irq_cause, C_MTI); end
    bus.i_take = 1'b1; tick(1); bus.i_take = 1'b0;
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL freeze_take got=%b want=0", bus.o_irq_req); end
  endtask

  task automatic test_withdraw();
    do_reset();
    bus.i_mie = 32'h80; bus.i_mstatus_mie = 1'b1; bus.i_mtip = 1'b1;
    tick(2);
    bus.i_mstatus_mie = 1'b0;
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL withdraw got=%b want=0", bus.o_irq_req); end
    tick(2);
    bus.i_mstatus_mie = 1'b1;
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL withdraw_reidle got=%b want=1", bus.o_irq_req); end
    bus.i_mstatus_mie = 1'b0; bus.i_take = 1'b1;
    tick(1);
    bus.i_mstatus_mie = 1'b1; bus.i_take = 1'b0;
    tick(2);
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL take_beats_mie got=%b want=0", bus.o_irq_req); end
  endtask

  task automatic test_sync();
    do_reset();
    bus.i_mie = 32'h800; bus.i_mstatus_mie = 1'b1; bus.i_meip_async = 1'b1;
    tick(MEI_LAT - 1);
    checks++; if (bus.o_mip !== 32'h0) begin errors++; $display("FAIL sync_early got=%h want=%h", bus.o_mip, 32'h0); end
    tick(1);
    checks++; if (bus.o_mip !== 32'h800 || bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL sync_mip got=%h/%b want=%h/0", bus.o_mip, bus.o_irq_req, 32'h800); end
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b1 || bus.o_irq_cause !== C_MEI) begin errors++; $display("FAIL sync_req got=%b/%h want=1/%h", bus.o_irq_req, bus.o_irq_cause, C_MEI); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.i_mie = 32'h80; bus.i_mstatus_mie = 1'b1; bus.i_mtip = 1'b1;
    tick(2);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.o_irq_req !== 1'b0 || bus.o_irq_cause !== 32'h0 || bus.o_mip !== 32'h0)
      begin errors++; $display("FAIL async_rst got=%b/%h/%h want=0/0/0", bus.o_irq_req, bus.o_irq_cause, bus.o_mip); end
    rst = 1'b0;
    tick(1);
    checks++; if (bus.o_mip !== 32'h80 || bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL rst_release1 got=%h/%b want=%h/0", bus.o_mip, bus.o_irq_req, 32'h80); end
    tick(1);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL rst_release2 got=%b want=1", bus.o_irq_req); end
  endtask

  task automatic test_ignored();
    do_reset();
    bus.i_mie = 32'h80;
    bus.i_take = 1'b1; bus.i_mret = 1'b1; tick(1); bus.i_take = 1'b0; bus.i_mret = 1'b0;
    bus.i_mtip = 1'b1; bus.i_mstatus_mie = 1'b1;
    tick(2);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL take_in_idle got=%b want=1", bus.o_irq_req); end
    bus.i_mret = 1'b1; tick(1); bus.i_mret = 1'b0;
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL mret_in_req got=%b want=1", bus.o_irq_req); end
  endtask

  task automatic test_idle_drop();
    do_reset();
    bus.i_mie = 32'h80; bus.i_mtip = 1'b1;
    tick(2);
    bus.i_mtip = 1'b0;
    tick(2);
    bus.i_mstatus_mie = 1'b1;
    tick(2);
    checks++; if (bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL idle_drop got=%b want=0", bus.o_irq_req); end
  endtask

`ifdef IRQ_CTRL_EXT_EDGE_EN
  task automatic test_edge();
    do_reset();
    bus.i_mie = 32'h800;
    bus.i_meip_async = 1'b1; tick(1); bus.i_meip_async = 1'b0;
    tick(8);
    checks++; if (bus.o_mip !== 32'h800) begin errors++; $display("FAIL edge_sticky got=%h want=%h", bus.o_mip, 32'h800); end
    bus.i_mstatus_mie = 1'b1;
    tick(1);
    checks++; if (bus.o_irq_cause !== C_MEI) begin errors++; $display("FAIL edge_cause got=%h want=%h", bus.o_irq_cause, C_MEI); end
    bus.i_take = 1'b1; tick(1); bus.i_take = 1'b0;
    checks++; if (bus.o_mip !== 32'h0) begin errors++; $display("FAIL edge_clear got=%h want=%h", bus.o_mip, 32'h0); end
    bus.i_mret = 1'b1; tick(1); bus.i_mret = 1'b0;
    bus.i_meip_async = 1'b1; tick(1); bus.i_meip_async = 1'b0;
    tick(8);
    checks++; if (bus.o_irq_req !== 1'b1) begin errors++; $display("FAIL edge_rereq got=%b want=1", bus.o_irq_req); end
    bus.i_meip_async = 1'b1;
    tick(SYNC);
    bus.i_take = 1'b1; tick(1); bus.i_take = 1'b0;
    checks++; if (bus.o_mip !== 32'h800 || bus.o_irq_req !== 1'b0) begin errors++; $display("FAIL edge_set_wins got=%h/%b want=%h/0", bus.o_mip, bus.o_irq_req, 32'h800); end
  endtask
`endif

  initial begin
    test_reset();
    test_timer();
    test_priority();
    test_freeze();
    test_withdraw();
    test_sync();
    test_async_reset();
    test_ignored();
    test_idle_drop();
`ifdef IRQ_CTRL_EXT_EDGE_EN
    test_edge();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
